// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/writeback units, the issue-stage scoreboard
// and the register bank write port.
interface regfile_wb_arbiter_if #(
   parameter int unsigned NREQ   = 3,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;
   logic                   rf_w_enable;
   logic [ADDR_W-1:0]      rf_waddr;
   logic [DATA_W-1:0]      rf_din;
   logic                   sb_set_valid;
   logic [ADDR_W-1:0]      sb_set_addr;
   logic                   sb_set_ready;
   logic [31:0]            sb_busy;
   logic                   sb_err;
   logic [15:0]            grant_cnt;

   modport slave (
      input  req_valid, req_addr, req_data, sb_set_valid, sb_set_addr,
      output req_ready, rf_w_enable, rf_waddr, rf_din, sb_set_ready, sb_busy, sb_err,
             grant_cnt
   );

   modport master (
      output req_valid, req_addr, req_data, sb_set_valid, sb_set_addr,
      input  req_ready, rf_w_enable, rf_waddr, rf_din, sb_set_ready, sb_busy, sb_err,
             grant_cnt
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register bank write port, with a registered write
// stage and a pending-write scoreboard for WAW stalls.
module regfile_wb_arbiter #(
   parameter int unsigned NREQ   = 3,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input logic                clk,
   input logic                reset,
   regfile_wb_arbiter_if.slave bus
);
   localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PtrW-1:0]   ptr_q, ptr_d, gidx, cand;
   int unsigned       idx;
   logic              found;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_data;
   logic              rf_en_q, rf_en_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [31:0]       busy_q, busy_d, clr_vec, set_vec;
   logic              err_q, err_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              set_ok;

   always_comb begin
      found = 1'b0;
      gidx  = '0;
      idx   = 0;
      cand  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx  = (32'(ptr_q) + k) % NREQ;
         cand = PtrW'(idx);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            gidx  = cand;
         end
      end
      g_addr = bus.req_addr[gidx*ADDR_W +: ADDR_W];
      g_data = bus.req_data[gidx*DATA_W +: DATA_W];
   end

   always_comb begin
      set_ok  = (bus.sb_set_addr == '0) || !busy_q[bus.sb_set_addr];
      clr_vec = (found && g_addr != '0) ? (32'h1 << g_addr) : 32'h0;
      set_vec = (bus.sb_set_valid && set_ok && bus.sb_set_addr != '0) ?
                (32'h1 << bus.sb_set_addr) : 32'h0;
      // A same-address set can only be accepted when the register is idle.
      busy_d    = (busy_q & ~clr_vec) | set_vec;
      busy_d[0] = 1'b0;
      err_d     = err_q | (found && g_addr != '0 && !busy_q[g_addr]);
      cnt_d     = cnt_q + (found ? 16'd1 : 16'd0);
      ptr_d     = ptr_q;
      if (found) ptr_d = (gidx == PtrW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      rf_en_d = found && (g_addr != '0);
      waddr_d = found ? g_addr : waddr_q;
      din_d   = found ? g_data : din_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q   <= '0;
         rf_en_q <= 1'b0;
         waddr_q <= '0;
         din_q   <= '0;
         busy_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         rf_en_q <= rf_en_d;
         waddr_q <= waddr_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.req_ready    = found ? (NREQ'(1) << gidx) : '0;
   assign bus.sb_set_ready = set_ok;
   assign bus.rf_w_enable  = rf_en_q;
   assign bus.rf_waddr     = waddr_q;
   assign bus.rf_din       = din_q;
   assign bus.sb_busy      = busy_q;
   assign bus.sb_err       = err_q;
   assign bus.grant_cnt    = cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;
   localparam int unsigned NREQ   = 3;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   regfile_wb_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Model state
   int          m_ptr;
   logic [31:0] m_busy;
   logic        m_err;
   logic [15:0] m_cnt;
   logic        m_en;
   logic [4:0]  m_waddr;
   logic [31:0] m_din;
   int          grants[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [4:0] addr_of(input int i);
      return bus.req_addr[i*ADDR_W +: ADDR_W];
   endfunction

   function automatic int find_grant();
      for (int k = 0; k < int'(NREQ); k++) begin
         int i;
         i = (m_ptr + k) % NREQ;
         if (bus.req_valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_busy = '0; m_err = 1'b0; m_cnt = '0;
      m_en = 1'b0; m_waddr = '0; m_din = '0;
   endtask

   // Checks every output at the falling edge, then advances the model across the next edge.
   task automatic cycle();
      int          g;
      logic [2:0]  exp_rdy;
      logic        exp_sr;
      logic [4:0]  a, sa;
      @(negedge clk);
      g = find_grant();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      sa = bus.sb_set_addr;
      exp_sr = (sa == 0) || !m_busy[sa];
      check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check("sb_set_ready", 32'(bus.sb_set_ready), 32'(exp_sr));
      check("rf_w_enable", 32'(bus.rf_w_enable), 32'(m_en));
      check("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
      check("rf_din", bus.rf_din, m_din);
      check("sb_busy", bus.sb_busy, m_busy);
      check("sb_err", 32'(bus.sb_err), 32'(m_err));
      check("grant_cnt", 32'(bus.grant_cnt), 32'(m_cnt));
      if (reset) begin
         model_reset();
      end else begin
         if (g >= 0) begin
            a       = addr_of(g);
            m_en    = (a != 0);
            m_waddr = a;
            m_din   = bus.req_data[g*DATA_W +: DATA_W];
            m_cnt   = m_cnt + 16'd1;
            if (a != 0) begin
               if (!m_busy[a]) m_err = 1'b1;
               m_busy[a] = 1'b0;
            end
            m_ptr = (g + 1) % NREQ;
            grants.push_back(g);
         end else begin
            m_en = 1'b0;
         end
         if (bus.sb_set_valid && exp_sr && sa != 0) m_busy[sa] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int i, input logic v, input logic [4:0] a,
                            input logic [31:0] d);
      bus.req_valid[i]               = v;
      bus.req_addr[i*ADDR_W +: ADDR_W] = a;
      bus.req_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic idle_inputs();
      bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
      bus.sb_set_valid = 1'b0; bus.sb_set_addr = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   int waddr_seq[$];

   initial begin
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      reset = 1'b0;

      // Reservation followed by a retiring write
      bus.sb_set_valid = 1'b1; bus.sb_set_addr = 5'd5;
      cycle();
      bus.sb_set_valid = 1'b0;
      check("t1_busy5", bus.sb_busy, 32'h20);
      drive_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
      #1 check("t1_ready", 32'(bus.req_ready), 32'h1);
      cycle();
      drive_req(0, 1'b0, 5'd0, 32'h0);
      check("t1_en", 32'(bus.rf_w_enable), 32'h1);
      check("t1_waddr", 32'(bus.rf_waddr), 32'd5);
      check("t1_din", bus.rf_din, 32'hDEADBEEF);
      check("t1_busy", bus.sb_busy, 32'h0);
      check("t1_cnt", 32'(bus.grant_cnt), 32'd1);

      // Round-robin from a fresh pointer
      do_reset();
      grants.delete();
      waddr_seq.delete();
      for (int i = 0; i < 3; i++) drive_req(i, 1'b1, 5'(i + 1), 32'(100 + i));
      repeat (6) begin
         cycle();
         waddr_seq.push_back(int'(bus.rf_waddr));
      end
      idle_inputs();
      check("rr_cnt", 32'(bus.grant_cnt), 32'd6);
      check("rr_ngrants", 32'(grants.size()), 32'd6);
      for (int i = 0; i < 6 && i < grants.size(); i++) begin
         check("rr_grant", 32'(grants[i]), 32'(i % 3));
         check("rr_waddr", 32'(waddr_seq[i]), 32'(i % 3 + 1));
      end

      // WAW stall on x7
      do_reset();
      bus.sb_set_valid = 1'b1; bus.sb_set_addr = 5'd7;
      cycle();
      #1 check("waw_stall", 32'(bus.sb_set_ready), 32'h0);
      drive_req(1, 1'b1, 5'd7, 32'h7777);
      cycle();
      drive_req(1, 1'b0, 5'd0, 32'h0);
      #1 check("waw_cleared", 32'(bus.sb_busy[7]), 32'h0);
      check("waw_ready", 32'(bus.sb_set_ready), 32'h1);
      check("waw_noerr", 32'(bus.sb_err), 32'h0);
      cycle();
      bus.sb_set_valid = 1'b0;
      check("waw_reset7", 32'(bus.sb_busy[7]), 32'h1);

      // x0 writes and the sticky error
      do_reset();
      drive_req(2, 1'b1, 5'd0, 32'h1234);
      #1 check("x0_ready", 32'(bus.req_ready), 32'h4);
      cycle();
      drive_req(2, 1'b0, 5'd0, 32'h0);
      check("x0_en", 32'(bus.rf_w_enable), 32'h0);
      check("x0_cnt", 32'(bus.grant_cnt), 32'd1);
      check("x0_err", 32'(bus.sb_err), 32'h0);
      drive_req(0, 1'b1, 5'd9, 32'h9999);
      cycle();
      drive_req(0, 1'b0, 5'd0, 32'h0);
      check("err_en", 32'(bus.rf_w_enable), 32'h1);
      check("err_set", 32'(bus.sb_err), 32'h1);
      repeat (3) cycle();
      check("err_sticky", 32'(bus.sb_err), 32'h1);

      // Reset landing on a transfer
      bus.sb_set_valid = 1'b1; bus.sb_set_addr = 5'd4;
      cycle();
      bus.sb_set_valid = 1'b0;
      drive_req(0, 1'b1, 5'd4, 32'h4444);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      drive_req(0, 1'b0, 5'd0, 32'h0);
      check("rst_en", 32'(bus.rf_w_enable), 32'h0);
      check("rst_busy", bus.sb_busy, 32'h0);
      check("rst_cnt", 32'(bus.grant_cnt), 32'h0);
      drive_req(1, 1'b1, 5'd1, 32'h11);
      drive_req(2, 1'b1, 5'd2, 32'h22);
      #1 check("rst_ptr0", 32'(bus.req_ready), 32'h2);
      repeat (2) cycle();
      idle_inputs();

      // Randomised traffic with occasional resets
      repeat (3000) begin
         for (int i = 0; i < 3; i++)
            drive_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom);
         bus.sb_set_valid = 1'($urandom_range(0, 1));
         bus.sb_set_addr  = 5'($urandom_range(0, 15));
         reset = ($urandom_range(0, 199) == 0);
         cycle();
      end
      reset = 1'b0;
      idle_inputs();

      // Counter wrap
      do_reset();
      drive_req(0, 1'b1, 5'd0, 32'h0);
      repeat (65535) cycle();
      check("wrap_max", 32'(bus.grant_cnt), 32'hFFFF);
      cycle();
      check("wrap_zero", 32'(bus.grant_cnt), 32'h0);
      idle_inputs();
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register bank's single write port between NREQ writeback sources (e.g. ALU, load unit, CSR unit) using round-robin arbitration with valid/ready handshakes. It drives the bank's write-enable, write-address and write-data from a registered output stage. It also keeps a 32-entry pending-write scoreboard that the issue stage uses to stall on write-after-write hazards. It sits between the execute/writeback units and the register bank.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NREQ  requester i has a write pending
req_ready  out  NREQ  requester i granted this cycle
req_addr  in  NREQ*ADDR_W  destination of requester i; slice i = bits [i*ADDR_W +: ADDR_W]
req_data  in  NREQ*DATA_W  write data of requester i; slice i = bits [i*DATA_W +: DATA_W]
rf_w_enable  out  1  write enable to the register bank
rf_waddr  out  ADDR_W  write address to the register bank
rf_din  out  DATA_W  write data to the register bank
sb_set_valid  in  1  issue stage reserves a destination register
sb_set_addr  in  ADDR_W  register being reserved
sb_set_ready  out  1  reservation accepted
sb_busy  out  32  pending-write bitmap; bit 0 is always 0
sb_err  out  1  sticky flag: a write retired to a non-busy register
grant_cnt  out  16  count of accepted writes; wraps at 0xFFFF -> 0

Behaviour:
- Reset (reset=1 at a rising edge): ptr=0, rf_w_enable=0, rf_waddr=0, rf_din=0, sb_busy=0, sb_err=0, grant_cnt=0. Reset wins over every simultaneous event. A write captured in the output stage is dropped: rf_w_enable=0 in the cycle after reset.
- Arbitration (combinational):
  - Search requesters ptr, ptr+1, ... mod NREQ; the first with req_valid=1 is granted (index g).
  - req_ready is one-hot, or all zero when no requester is valid.
  - req_ready[i] never asserts without req_valid[i].
- Handshake: a transfer occurs when req_valid[g] & req_ready[g]. On that edge:
  - ptr <= (g+1) mod NREQ.
  - grant_cnt increments.
  - If no transfer occurs, ptr holds.
- Output stage, 1-cycle latency. The cycle after a transfer:
  - rf_w_enable = (req_addr[g] != 0).
  - rf_waddr = req_addr[g], rf_din = req_data[g].
  - With no transfer, rf_w_enable=0 and rf_waddr/rf_din hold their last values.
- Writes to x0 are accepted (ready, counted) but never enabled and never touch the scoreboard.
- Throughput: one write per cycle, back-to-back. No requester waits more than NREQ-1 grants while continuously valid.
- Scoreboard reservation:
  - sb_set_ready = (sb_set_addr == 0) | ~sb_busy[sb_set_addr] (combinational).
  - When sb_set_valid & sb_set_ready and addr != 0, sb_busy[addr] <= 1 on that edge.
- Scoreboard clear:
  - A transfer with addr a != 0 clears sb_busy[a] on the same edge. sb_busy falls in the same cycle rf_w_enable rises.
  - If sb_busy[a] was already 0, sb_err <= 1. sb_err stays set until reset.
- Simultaneous set and clear:
  - Different addresses: both are applied.
  - Same address: the set cannot be accepted, because the register is busy and sb_set_ready=0. The clear applies. Reservation succeeds the next cycle.
- Requester data/addr only need to be stable while valid and not yet granted. Dropping valid before grant is permitted and has no effect.

Test Plan:
- Reset then idle: sb_set x5, then req0 writes x5=0xDEADBEEF -> sb_busy[5]=1 after set; req_ready[0]=1; next cycle rf_w_enable=1, rf_waddr=5, rf_din=0xDEADBEEF, sb_busy=0, grant_cnt=1.
- Round-robin: all three valid for 6 cycles with addrs 1/2/3 -> grant order 0,1,2,0,1,2; rf_waddr sequence 1,2,3,1,2,3 lagging by one cycle; grant_cnt=6.
- WAW stall: x7 busy, sb_set_valid addr 7 -> sb_set_ready=0. In the cycle req1 writes x7: sb_busy[7] clears and sb_set_ready=1 next cycle. The set then lands and sb_busy[7]=1 again.
- x0 and error: req2 writes x0 -> ready=1, rf_w_enable=0, grant_cnt increments, sb_err=0. Then a write to non-busy x9 -> rf_w_enable=1, sb_err=1, which persists until reset.
- Reset mid-operation: transfer of x4 on the edge where reset=1 -> next cycle rf_w_enable=0, sb_busy=0, ptr=0, grant_cnt=0. Holding req1 and req2 valid afterwards grants req1 first.
- Counter wrap: preload by 65535 transfers, then one more -> grant_cnt=0.
